// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot sequencer: zero-fills instruction memory, loads a byte-serial image, releases the CPU
// Image: 16-bit big-endian word count N, then N big-endian 32-bit words.
module imem_boot_loader #(
   parameter int IMEM_DEPTH = 256,
   parameter int ADDR_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_data_o,
   output logic              start_o,
   output logic              busy_o,
   output logic              err_o,
   output logic [ADDR_W:0]   word_cnt_o
);
   typedef enum logic [2:0] {
      S_CLEAR,
      S_HDR_HI,
      S_HDR_LO,
      S_LOAD,
      S_RUN,
      S_ERR
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(IMEM_DEPTH);
   localparam logic [15:0]     DEPTH_16 = 16'(IMEM_DEPTH);

   state_t            r_state;
   state_t            w_nxt;
   logic [ADDR_W:0]   r_clr_addr;
   logic [15:0]       r_hdr;
   logic [23:0]       r_asm;
   logic [1:0]        r_bcnt;
   logic              r_pend;
   logic              r_ready;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic              r_start;
   logic              r_busy;
   logic              r_err;
   logic [ADDR_W:0]   r_wcnt;

   logic              w_acc;
   logic              w_wr;
   logic              w_last;
   logic              w_clr_wr;
   logic [15:0]       w_n_full;
   logic [15:0]       w_cnt_inc;

   always_comb begin
      w_nxt     = r_state;
      w_acc     = byte_valid_i && r_ready;
      w_wr      = 1'b0;
      w_last    = 1'b0;
      w_clr_wr  = 1'b0;
      w_n_full  = {r_hdr[15:8], byte_i};
      w_cnt_inc = 16'(r_wcnt) + 16'd1;
      case (r_state)
         S_CLEAR: begin
            // The counter runs one past the last address so the final zero write
            // lands before byte_ready_o rises.
            if (r_clr_addr == DEPTH_W) w_nxt = S_HDR_HI;
            else                       w_clr_wr = 1'b1;
         end
         S_HDR_HI: if (w_acc) w_nxt = S_HDR_LO;
         S_HDR_LO: begin
            if (w_acc) begin
               if (w_n_full == 16'd0)          w_nxt = S_RUN;
               else if (w_n_full > DEPTH_16)   w_nxt = S_ERR;
               else                            w_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (r_pend) begin
               w_nxt = S_RUN;
            end else if (w_acc && r_bcnt == 2'd3) begin
               w_wr   = 1'b1;
               w_last = (w_cnt_inc == r_hdr);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_CLEAR;
         r_clr_addr <= '0;
         r_hdr      <= '0;
         r_asm      <= '0;
         r_bcnt     <= '0;
         r_pend     <= 1'b0;
         r_ready    <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_start    <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_wcnt     <= '0;
      end else begin
         r_state <= w_nxt;
         r_we    <= 1'b0;
         if (w_clr_wr) begin
            r_we       <= 1'b1;
            r_addr     <= r_clr_addr[ADDR_W-1:0];
            r_data     <= 32'd0;
            r_clr_addr <= r_clr_addr + (ADDR_W+1)'(1);
         end
         if (r_state == S_HDR_HI && w_acc) r_hdr[15:8] <= byte_i;
         if (r_state == S_HDR_LO && w_acc) r_hdr[7:0]  <= byte_i;
         if (r_state == S_LOAD && w_acc) begin
            r_asm  <= {r_asm[15:0], byte_i};
            r_bcnt <= r_bcnt + 2'd1;
         end
         if (w_wr) begin
            r_we   <= 1'b1;
            r_addr <= r_wcnt[ADDR_W-1:0];
            r_data <= {r_asm, byte_i};
            r_wcnt <= r_wcnt + (ADDR_W+1)'(1);
         end
         if (w_last) r_pend <= 1'b1;
         // Ready drops during the final write so trailing bytes are never taken.
         r_ready <= (w_nxt inside {S_HDR_HI, S_HDR_LO, S_LOAD}) && !w_last;
         r_busy  <= (w_nxt inside {S_CLEAR, S_HDR_HI, S_HDR_LO, S_LOAD});
         r_start <= (w_nxt == S_RUN);
         r_err   <= (w_nxt == S_ERR);
      end
   end

   assign byte_ready_o = r_ready;
   assign imem_we_o    = r_we;
   assign imem_addr_o  = r_addr;
   assign imem_data_o  = r_data;
   assign start_o      = r_start;
   assign busy_o       = r_busy;
   assign err_o        = r_err;
   assign word_cnt_o   = r_wcnt;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_i = 8'h00;
   logic        byte_ready_o;
   logic        imem_we_o;
   logic [7:0]  imem_addr_o;
   logic [31:0] imem_data_o;
   logic        start_o;
   logic        busy_o;
   logic        err_o;
   logic [8:0]  word_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [39:0] sb[$];
   logic [39:0] exp_w;

   imem_boot_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
      .byte_ready_o(byte_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
      .imem_data_o(imem_data_o), .start_o(start_o), .busy_o(busy_o), .err_o(err_o),
      .word_cnt_o(word_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // every observed write must match the oldest expected {addr,data}
   always @(negedge clk_i) begin
      if (!rst_i && imem_we_o) begin
         n_checks++;
         if (sb.size() != 0) exp_w = sb.pop_front();
         else                exp_w = 'x;
         assert ({imem_addr_o, imem_data_o} === exp_w) else begin
            n_fail++;
            $error("FAIL write: observed %h expected %h", {imem_addr_o, imem_data_o}, exp_w);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_clear();
      int t;
      @(negedge clk_i);
      rst_i = 1'b1;
      byte_valid_i = 1'b0;
      #1;
      chk("reset_outputs", {byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, start_o, busy_o, err_o, word_cnt_o}, 64'd0);
      repeat (2) @(negedge clk_i);
      for (int i = 0; i < 256; i++) sb.push_back({i[7:0], 32'd0});
      rst_i = 1'b0;
      t = 0;
      do begin
         @(negedge clk_i);
         t++;
      end while (!byte_ready_o && t < 400);
      chk("clear_cycles", t, 257);
      chk("clear_sb_drained", sb.size(), 0);
      chk("after_clear", {byte_ready_o, busy_o, start_o, imem_we_o, err_o}, 5'b11000);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk_i);
      byte_valid_i = 1'b1;
      byte_i = b;
      t = 0;
      while (!byte_ready_o && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= 50) chk("ready_timeout", 1, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      byte_valid_i = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] a, input logic [31:0] w, input int gap);
      sb.push_back({a, w});
      for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
   endtask

   task automatic image2(input int gap);
      send_byte(8'h00, gap);
      send_byte(8'h02, gap);
      send_word(8'd0, 32'h8C020000, gap);
      send_word(8'd1, 32'h00221820, gap);
      chk("last_write_cycle", {start_o, imem_we_o, word_cnt_o}, {1'b0, 1'b1, 9'd2});
      @(negedge clk_i);
      chk("run_state", {start_o, busy_o, byte_ready_o, imem_we_o, word_cnt_o}, {4'b1000, 9'd2});
      chk("image2_sb_drained", sb.size(), 0);
   endtask

   initial begin
      logic bad;
      logic [31:0] w;
      // 1: clear after reset
      reset_clear();

      // 2: two-word image back to back, then trailing bytes must be ignored
      image2(0);
      byte_valid_i = 1'b1;
      byte_i = 8'hFF;
      repeat (10) @(negedge clk_i);
      byte_valid_i = 1'b0;
      chk("run_hold", {start_o, byte_ready_o, word_cnt_o}, {2'b10, 9'd2});

      // 3: same image with a byte every third cycle
      reset_clear();
      image2(2);

      // 4: oversize header
      reset_clear();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      chk("err_state", {err_o, byte_ready_o, start_o, busy_o}, 4'b1000);
      bad = 1'b0;
      byte_valid_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         byte_i = i[7:0];
         @(negedge clk_i);
         if (start_o || !err_o || byte_ready_o) bad = 1'b1;
      end
      byte_valid_i = 1'b0;
      chk("err_hold_100", bad, 1'b0);

      // 5: empty image
      reset_clear();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("n0_run", {start_o, busy_o, byte_ready_o, word_cnt_o}, {3'b100, 9'd0});

      // full-depth image: last write lands at address 255
      reset_clear();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 256; i++) begin
         w = {i[7:0], ~i[7:0], 8'hA5, i[7:0] ^ 8'h3C};
         send_word(i[7:0], w, 0);
      end
      chk("full_last_write", {start_o, imem_we_o, imem_addr_o, word_cnt_o}, {2'b01, 8'd255, 9'd256});
      @(negedge clk_i);
      chk("full_run", {start_o, busy_o, err_o}, 3'b100);

      // 6: reset after 5 image bytes
      reset_clear();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      sb.push_back({8'd0, 32'h8C020000});
      send_byte(8'h8C, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      chk("partial_no_write", {imem_we_o, word_cnt_o, busy_o}, {1'b0, 9'd0, 1'b1});
      void'(sb.pop_back());
      reset_clear();
      chk("final_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
